// File: rtl/mem_access_ctrl.sv
// Single-port word-memory access controller: one request at a time, address and
// controls held for WAIT_CYCLES cycles, then a one-cycle completion pulse.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    // Request handshake: a transfer is accepted on a rising edge where
    // req_valid and req_ready are both 1. req_ready is high only in IDLE, and
    // the request fields are sampled on that edge only; at any other time
    // req_valid and the fields are ignored.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [11:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // 0 behaves as 1; values beyond the 4-bit counter range saturate.
    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 :
                              ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_EFF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        first_q, first_d;
    logic [11:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            first_q <= 1'b0;
            addr_q  <= 12'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            first_q <= first_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        first_d = first_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    wr_d    = req_write;
                    first_d = 1'b1;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            ACCESS: begin
                first_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (!wr_q) rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controls decode straight from the state so an asynchronous reset drops
    // them in the same instant it forces IDLE.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign mem_read  = (state_q == ACCESS) && !wr_q;
    assign mem_write = (state_q == ACCESS) && wr_q && first_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with WAIT_CYCLES=1 and one
// with WAIT_CYCLES=3, each attached to its own 4096x16 memory model.
module tb_mem_access_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [11:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_rdata [2];
    logic        mem_read  [2];
    logic        mem_write [2];
    logic [11:0] mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic [1:0]  dbg_state [2];

    logic [15:0] mem [2][4096];

    mem_access_ctrl #(.WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .dbg_state(dbg_state[0])
    );

    mem_access_ctrl #(.WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .dbg_state(dbg_state[1])
    );

    // Memory models: synchronous write, combinational read while mem_read=1.
    always @(posedge clk) if (mem_write[0]) mem[0][mem_addr[0]] <= mem_wdata[0];
    always @(posedge clk) if (mem_write[1]) mem[1][mem_addr[1]] <= mem_wdata[1];
    assign mem_rdata[0] = mem_read[0] ? mem[0][mem_addr[0]] : 16'hDEAD;
    assign mem_rdata[1] = mem_read[1] ? mem[1][mem_addr[1]] : 16'hDEAD;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_bad    = 0;
    logic [16:0] exp_q[$];   // {is_read, expected rdata}

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input int d);
        check_eq("rst_ready",     32'(req_ready[d]), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        check_eq("rst_mem_read",  32'(mem_read[d]),  32'd0);
        check_eq("rst_mem_write", 32'(mem_write[d]), 32'd0);
        check_eq("rst_mem_addr",  32'(mem_addr[d]),  32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata[d]), 32'd0);
        check_eq("rst_rsp_rdata", 32'(rsp_rdata[d]), 32'd0);
    endtask

    // ---------------- driver ----------------
    // One transfer; request fields are scrambled once accepted to show they are ignored.
    task automatic xfer(input int d, input logic wr, input logic [11:0] a, input logic [15:0] wd,
                        output int lat, output int rd_cyc, output int wr_cyc,
                        output int busy_cyc, output logic [15:0] rdata);
        int   k;
        logic got;
        lat = -1; rd_cyc = 0; wr_cyc = 0; busy_cyc = 0; rdata = 16'h0; got = 1'b0; k = 0;
        @(negedge clk);
        check_eq("ready_before", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd;
        @(posedge clk);
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            req_valid[d] = 1'b0; req_write[d] = ~wr; req_addr[d] = ~a; req_wdata[d] = ~wd;
            if (mem_read[d])  rd_cyc++;
            if (mem_write[d]) wr_cyc++;
            if (!req_ready[d]) busy_cyc++;
            if (mem_read[d] || mem_write[d]) check_eq("access_addr", 32'(mem_addr[d]), 32'(a));
            if (mem_write[d]) check_eq("access_wdata", 32'(mem_wdata[d]), 32'(wd));
            if (rsp_valid[d]) begin
                got = 1'b1; lat = k; rdata = rsp_rdata[d];
            end
        end
        if (!got) check_eq("rsp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check_eq("rsp_one_cycle", 32'(rsp_valid[d]), 32'd0);
        check_eq("ready_after",   32'(req_ready[d]), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, rdc, wrc, busy, pulses, n;
        logic [15:0] rd;
        logic acc;
        logic [16:0] e;
        int acc_cyc [4];
        logic        op_wr  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [11:0] op_addr[4] = '{12'h123, 12'h123, 12'h124, 12'h124};
        logic [15:0] op_data[4] = '{16'hA5A5, 16'h0000, 16'h5A5A, 16'h0000};
        logic [15:0] op_exp [4] = '{16'h0000, 16'hA5A5, 16'h0000, 16'h5A5A};

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 12'h0; req_wdata[d] = 16'h0;
            for (int i = 0; i < 4096; i++) mem[d][i] = 16'h0;
        end
        mem[1][12'hFFF] = 16'h1234;

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b1;

        // WAIT_CYCLES=1: write then read back
        xfer(0, 1'b1, 12'h010, 16'hBEEF, lat, rdc, wrc, busy, rd);
        check_eq("w1_wr_lat",    32'(lat), 32'd2);
        check_eq("w1_wr_wcyc",   32'(wrc), 32'd1);
        check_eq("w1_wr_rcyc",   32'(rdc), 32'd0);
        check_eq("w1_wr_mem",    32'(mem[0][12'h010]), 32'hBEEF);
        check_eq("w1_wr_rdata0", 32'(rsp_rdata[0]), 32'h0);

        xfer(0, 1'b0, 12'h010, 16'h0000, lat, rdc, wrc, busy, rd);
        check_eq("w1_rd_lat",   32'(lat), 32'd2);
        check_eq("w1_rd_rcyc",  32'(rdc), 32'd1);
        check_eq("w1_rd_wcyc",  32'(wrc), 32'd0);
        check_eq("w1_rd_data",  32'(rd),  32'hBEEF);
        repeat (3) @(negedge clk);
        check_eq("w1_rd_hold",  32'(rsp_rdata[0]), 32'hBEEF);

        // a write must leave rsp_rdata alone; idle outputs hold the last latched values
        xfer(0, 1'b1, 12'hFFF, 16'hCAFE, lat, rdc, wrc, busy, rd);
        check_eq("w1_wr2_mem",   32'(mem[0][12'hFFF]), 32'hCAFE);
        check_eq("w1_wr2_rdata", 32'(rsp_rdata[0]), 32'hBEEF);
        check_eq("idle_addr",    32'(mem_addr[0]),  32'hFFF);
        check_eq("idle_wdata",   32'(mem_wdata[0]), 32'hCAFE);
        check_eq("idle_mem_wr",  32'(mem_write[0]), 32'd0);

        // req_valid pulse entirely between edges has no effect
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 12'h200; req_wdata[0] = 16'h1111;
        #2 req_valid[0] = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_write[0] || mem_read[0] || rsp_valid[0] || !req_ready[0]) pulses++;
        end
        check_eq("glitch_activity", 32'(pulses), 32'd0);
        check_eq("glitch_mem",      32'(mem[0][12'h200]), 32'h0);

        // WAIT_CYCLES=3: read of top address
        xfer(1, 1'b0, 12'hFFF, 16'h0000, lat, rdc, wrc, busy, rd);
        check_eq("w3_rd_lat",  32'(lat),  32'd4);
        check_eq("w3_rd_rcyc", 32'(rdc),  32'd3);
        check_eq("w3_rd_busy", 32'(busy), 32'd4);
        check_eq("w3_rd_data", 32'(rd),   32'h1234);

        // back-to-back with req_valid held high
        @(negedge clk);
        n = 0; pulses = 0;
        req_valid[1] = 1'b1; req_write[1] = op_wr[0]; req_addr[1] = op_addr[0]; req_wdata[1] = op_data[0];
        for (int c = 0; c < 60 && (n < 4 || exp_q.size() > 0); c++) begin
            if (c > 0) @(negedge clk);
            acc = 1'b0;
            if (rsp_valid[1]) begin
                pulses++;
                if (exp_q.size() == 0) check_eq("sb_extra_rsp", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    if (e[16]) check_eq("sb_rdata", 32'(rsp_rdata[1]), 32'(e[15:0]));
                end
            end
            if (req_ready[1] && req_valid[1] && n < 4) begin
                acc_cyc[n] = c;
                exp_q.push_back({!op_wr[n], op_exp[n]});
                n++;
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (n < 4) begin
                    req_write[1] = op_wr[n]; req_addr[1] = op_addr[n]; req_wdata[1] = op_data[n];
                end else begin
                    req_valid[1] = 1'b0;
                end
            end
        end
        check_eq("b2b_accepts", 32'(n), 32'd4);
        check_eq("b2b_rsps",    32'(pulses), 32'd4);
        check_eq("b2b_pending", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) check_eq("b2b_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd5);
        check_eq("b2b_mem_123", 32'(mem[1][12'h123]), 32'hA5A5);
        check_eq("b2b_mem_124", 32'(mem[1][12'h124]), 32'h5A5A);

        // reset asserted during the first ACCESS cycle of a write
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 12'h055; req_wdata[1] = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check_eq("abort_wr_before", 32'(mem_write[1]), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_reset_outputs(1);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[1] || mem_write[1]) pulses++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid[1]) pulses++;
        end
        check_eq("abort_no_rsp", 32'(pulses), 32'd0);
        check_eq("abort_mem",    32'(mem[1][12'h055]), 32'h0);

        // normal traffic after the aborted transfer
        xfer(1, 1'b1, 12'h055, 16'h7777, lat, rdc, wrc, busy, rd);
        check_eq("post_wr_lat",  32'(lat), 32'd4);
        check_eq("post_wr_wcyc", 32'(wrc), 32'd1);
        check_eq("post_wr_mem",  32'(mem[1][12'h055]), 32'h7777);
        xfer(1, 1'b0, 12'h123, 16'h0000, lat, rdc, wrc, busy, rd);
        check_eq("post_rd_lat",  32'(lat), 32'd4);
        check_eq("post_rd_data", 32'(rd),  32'hA5A5);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, giving the number of cycles the memory address and controls are held per access (legal 1..15; 0 SHALL behave as 1).
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  requester has a transfer pending.
REQ-005 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-006 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  12  word address.
REQ-008 SHALL have port req_wdata  input  16  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  16  data returned by the last completed read.
REQ-011 SHALL have port mem_read  output  1  read enable to the 4096x16 word memory.
REQ-012 SHALL have port mem_write  output  1  write enable to the memory, sampled at the memory's rising clk edge.
REQ-013 SHALL have port mem_addr  output  12  memory address.
REQ-014 SHALL have port mem_wdata  output  16  memory write data.
REQ-015 SHALL have port mem_rdata  input  16  memory read data, combinational from mem_addr while mem_read=1.

Function
REQ-016 SHALL implement the states IDLE, ACCESS and RESP, with a 4-bit wait counter.
REQ-017 req_ready SHALL be 1 exactly when the state is IDLE.
REQ-018 Acceptance edge: req_valid=1 and req_ready=1.
- On that edge the controller SHALL latch req_write, req_addr and req_wdata.
- It SHALL load the counter with WAIT_CYCLES-1 and enter ACCESS.
REQ-019 In ACCESS, mem_addr and mem_wdata SHALL come from the latched registers, and the request inputs SHALL be ignored.
REQ-020 Read in ACCESS: mem_read SHALL be 1 for every ACCESS cycle, and mem_write SHALL be 0.
REQ-021 Write in ACCESS: mem_write SHALL be 1 only in the first ACCESS cycle, and mem_read SHALL be 0 throughout.
REQ-022 ACCESS counter:
- The counter SHALL decrement each ACCESS cycle.
- On the edge where the counter is 0, the FSM SHALL enter RESP.
- For a read, that same edge SHALL capture mem_rdata into rsp_rdata.
REQ-023 In RESP:
- rsp_valid SHALL be 1 for exactly one cycle, for both reads and writes.
- mem_read and mem_write SHALL be 0.
- The next edge SHALL return the FSM to IDLE.
REQ-024 Latency: with acceptance on edge E0, rsp_valid SHALL be high in the cycle after edge E0+WAIT_CYCLES.
REQ-025 Throughput SHALL be one transfer per WAIT_CYCLES+2 cycles; no request SHALL be accepted in ACCESS or RESP.
REQ-026 rsp_rdata SHALL hold its value until the next read completes, and writes SHALL NOT change it.
REQ-027 In IDLE, mem_read and mem_write SHALL be 0, and mem_addr/mem_wdata SHALL hold the last latched values.
REQ-028 A req_valid that drops before acceptance SHALL leave no effect.
REQ-029 An address of 12'hFFF SHALL be passed unmodified, with no wrap or increment logic.

Reset
REQ-030 While rst=0, the following SHALL be forced asynchronously:
- state IDLE and counter 0;
- rsp_valid, mem_read and mem_write 0;
- mem_addr, mem_wdata and rsp_rdata 0;
- req_ready 1.
REQ-031 Reset asserted mid-ACCESS SHALL drop mem_read/mem_write immediately, and no rsp_valid SHALL follow for the aborted transfer.
REQ-032 Requests SHALL be accepted from the first rising edge after rst returns to 1.

Verification
REQ-033 WAIT_CYCLES=1, write addr 12'h010 data 16'hBEEF -> mem_write high exactly 1 cycle, rsp_valid high in the cycle after E0+1, memory word 0x010 = 16'hBEEF.
REQ-034 WAIT_CYCLES=1, read addr 12'h010 after REQ-033 -> mem_read high 1 cycle, rsp_rdata = 16'hBEEF with rsp_valid, and the value held afterwards.
REQ-035 WAIT_CYCLES=3, read addr 12'hFFF preloaded 16'h1234 -> mem_read high 3 cycles, req_ready low 4 cycles, rsp_rdata = 16'h1234.
REQ-036 req_valid held high continuously with alternating write/read -> acceptances spaced WAIT_CYCLES+2 cycles apart, no request lost or duplicated.
REQ-037 rst pulled low during ACCESS of a write with WAIT_CYCLES=3 -> mem_write low immediately, no rsp_valid, all outputs at reset values, next request completes normally.
